// File: rtl/alu_control_data_mem.sv
// Execute/memory stage: opcode decode, 8-bit ALU, 256x8 data memory; comb zero-cycle path, no backpressure.
// Stores and flags commit on the clock edge; ALU_FLAGS_EN builds the Z/C/V flag register (else flags read 0).
module alu_control_data_mem (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] op_code,
  input  logic [7:0] t0_data,
  input  logic [7:0] t1_data,
  input  logic [2:0] imm_bits,
  output logic       jump_sig,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic [7:0] alu_result,
  output logic [7:0] writeback,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_v
);

  typedef struct packed {
    logic [2:0] alu_op;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
  } ctrl_t;

  ctrl_t      ctrl;
  logic [7:0] imm_ext;
  logic [7:0] opnd_b;
  logic [7:0] read_data;
  logic [7:0] mem [256];

  always_comb begin
    ctrl = '0;
    case (op_code)
      3'b000: ctrl = '{alu_op: 3'b000, reg_write: 1'b1, alu_src: 1'b0, mem_read: 1'b0, mem_write: 1'b0, jump: 1'b0};
      3'b001: ctrl = '{alu_op: 3'b001, reg_write: 1'b1, alu_src: 1'b0, mem_read: 1'b0, mem_write: 1'b0, jump: 1'b0};
      3'b010: ctrl = '{alu_op: 3'b010, reg_write: 1'b1, alu_src: 1'b0, mem_read: 1'b0, mem_write: 1'b0, jump: 1'b0};
      3'b011: ctrl = '{alu_op: 3'b011, reg_write: 1'b1, alu_src: 1'b0, mem_read: 1'b0, mem_write: 1'b0, jump: 1'b0};
      3'b100: ctrl = '{alu_op: 3'b000, reg_write: 1'b1, alu_src: 1'b1, mem_read: 1'b0, mem_write: 1'b0, jump: 1'b0};
      3'b101: ctrl = '{alu_op: 3'b000, reg_write: 1'b1, alu_src: 1'b1, mem_read: 1'b1, mem_write: 1'b0, jump: 1'b0};
      3'b110: ctrl = '{alu_op: 3'b000, reg_write: 1'b0, alu_src: 1'b1, mem_read: 1'b0, mem_write: 1'b1, jump: 1'b0};
      default: ctrl = '{alu_op: 3'b000, reg_write: 1'b0, alu_src: 1'b0, mem_read: 1'b0, mem_write: 1'b0, jump: 1'b1};
    endcase
  end

  assign jump_sig  = ctrl.jump;
  assign reg_write = ctrl.reg_write;
  assign mem_read  = ctrl.mem_read;
  assign mem_write = ctrl.mem_write;
  assign alu_src   = ctrl.alu_src;
  assign alu_op    = ctrl.alu_op;

  assign imm_ext = {{5{imm_bits[2]}}, imm_bits};
  assign opnd_b  = ctrl.alu_src ? imm_ext : t1_data;

  always_comb begin
    alu_result = t0_data + opnd_b;
    case (ctrl.alu_op)
      3'b001:  alu_result = t0_data - opnd_b;
      3'b010:  alu_result = t0_data & opnd_b;
      3'b011:  alu_result = t0_data | opnd_b;
      default: alu_result = t0_data + opnd_b;
    endcase
  end

  // Old data is visible until the write edge, so the read stays a plain array lookup.
  assign read_data = mem[alu_result];
  assign writeback = ctrl.mem_read ? read_data : alu_result;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (ctrl.mem_write) begin
      mem[alu_result] <= t1_data;
    end
  end

`ifdef ALU_FLAGS_EN
  logic [8:0] add9;
  logic [8:0] sub9;
  logic       nxt_c;
  logic       nxt_v;
  logic       flag_upd;

  assign add9     = {1'b0, t0_data} + {1'b0, opnd_b};
  assign sub9     = {1'b0, t0_data} - {1'b0, opnd_b};
  assign flag_upd = ~op_code[2] | (op_code == 3'b100);

  // Bit 8 of the 9-bit difference is the unsigned borrow.
  always_comb begin
    nxt_c = 1'b0;
    nxt_v = 1'b0;
    case (ctrl.alu_op)
      3'b000: begin
        nxt_c = add9[8];
        nxt_v = (t0_data[7] == opnd_b[7]) && (add9[7] != t0_data[7]);
      end
      3'b001: begin
        nxt_c = sub9[8];
        nxt_v = (t0_data[7] != opnd_b[7]) && (sub9[7] != t0_data[7]);
      end
      default: begin
        nxt_c = 1'b0;
        nxt_v = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (flag_upd) begin
      flag_z <= (alu_result == 8'h00);
      flag_c <= nxt_c;
      flag_v <= nxt_v;
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_data_mem.sv
// Randomized bench for alu_control_data_mem against an arithmetic reference model with its own memory image.
module tb_alu_control_data_mem;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] op_code = 3'b000;
  logic [7:0] t0_data = 8'h00;
  logic [7:0] t1_data = 8'h00;
  logic [2:0] imm_bits = 3'b000;
  logic       jump_sig, reg_write, mem_read, mem_write, alu_src;
  logic [2:0] alu_op;
  logic [7:0] alu_result, writeback;
  logic       flag_z, flag_c, flag_v;

  int checks = 0;
  int errors = 0;

  int m_mem [256];
  int m_z = 0, m_c = 0, m_v = 0;
  int e_res, e_wb, e_z, e_c, e_v;
  logic [7:0] e_ctrl;

  alu_control_data_mem dut (
    .clock(clock), .reset_n(reset_n), .op_code(op_code), .t0_data(t0_data),
    .t1_data(t1_data), .imm_bits(imm_bits), .jump_sig(jump_sig), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .alu_op(alu_op),
    .alu_result(alu_result), .writeback(writeback), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference: control vector {jump, reg_write, mem_read, mem_write, alu_src, alu_op}, result, flags.
  task automatic model_eval();
    int a, b, op, s, full;
    op = int'(op_code);
    a  = int'(t0_data);
    case (op)
      0: e_ctrl = {5'b01000, 3'd0};
      1: e_ctrl = {5'b01000, 3'd1};
      2: e_ctrl = {5'b01000, 3'd2};
      3: e_ctrl = {5'b01000, 3'd3};
      4: e_ctrl = {5'b01001, 3'd0};
      5: e_ctrl = {5'b01101, 3'd0};
      6: e_ctrl = {5'b00011, 3'd0};
      default: e_ctrl = {5'b10000, 3'd0};
    endcase
    b = (op >= 4 && op <= 6) ? ((int'(imm_bits) >= 4) ? int'(imm_bits) + 248 : int'(imm_bits))
                             : int'(t1_data);
    e_c = 0;
    e_v = 0;
    if (op == 1) begin
      full  = a - b;
      e_res = (full + 256) % 256;
      e_c   = (a < b) ? 1 : 0;
      s     = sgn(a) - sgn(b);
      e_v   = (s > 127 || s < -128) ? 1 : 0;
    end else if (op == 2) begin
      e_res = a & b;
    end else if (op == 3) begin
      e_res = a | b;
    end else begin
      full  = a + b;
      e_res = full % 256;
      e_c   = (full > 255) ? 1 : 0;
      s     = sgn(a) + sgn(b);
      e_v   = (s > 127 || s < -128) ? 1 : 0;
    end
    e_z  = (e_res == 0) ? 1 : 0;
    e_wb = (op == 5) ? m_mem[e_res] : e_res;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 0;
    m_z = 0; m_c = 0; m_v = 0;
  endtask

  task automatic check_flags(input string tag);
`ifdef ALU_FLAGS_EN
    check({tag, "_flags"}, {13'd0, flag_z, flag_c, flag_v}, {13'd0, m_z[0], m_c[0], m_v[0]});
`else
    check({tag, "_flags"}, {13'd0, flag_z, flag_c, flag_v}, 16'd0);
`endif
  endtask

  // One instruction: drive after the falling edge, check the comb path, commit at the rising edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] imm);
    @(negedge clock);
    op_code = op; t0_data = a; t1_data = b; imm_bits = imm;
    #1;
    model_eval();
    check({tag, "_ctrl"}, {8'd0, jump_sig, reg_write, mem_read, mem_write, alu_src, alu_op},
          {8'd0, e_ctrl});
    check({tag, "_res"}, {8'd0, alu_result}, e_res[15:0]);
    check({tag, "_wb"}, {8'd0, writeback}, e_wb[15:0]);
    @(posedge clock);
    if (reset_n) begin
      if (op == 3'b110) m_mem[e_res] = int'(b);
      if (op <= 3'b100) begin m_z = e_z; m_c = e_c; m_v = e_v; end
    end
    #1;
    check_flags(tag);
  endtask

  task automatic async_reset_pulse();
    @(negedge clock);
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_flags("async_rst");
    run_op("sw_in_rst", 3'b110, 8'(
      $urandom_range(0, 255)), 8'($urandom_range(1, 255)), 3'($urandom_range(0, 7)));
    @(negedge clock);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 check_flags("reset");
    @(negedge clock);
    #1 op_code = 3'b101; t0_data = 8'h10; imm_bits = 3'b000;
    #1 check("rst_lw_wb", {8'd0, writeback}, 16'h0000);
    run_op("rst_lw", 3'b101, 8'h10, 8'h00, 3'b000);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("sw_a5", 3'b110, 8'h20, 8'hA5, 3'b111);
    run_op("lw_a5", 3'b101, 8'h1F, 8'h00, 3'b000);
    check("lw_a5_val", {8'd0, writeback}, 16'h00A5);
    run_op("add_ff", 3'b000, 8'hFF, 8'h01, 3'b000);
    run_op("sub_80", 3'b001, 8'h80, 8'h01, 3'b000);
    run_op("sub_01", 3'b001, 8'h01, 8'h02, 3'b000);
    run_op("addi_m4", 3'b100, 8'h05, 8'h00, 3'b100);
    run_op("jump", 3'b111, 8'h12, 8'h34, 3'b000);
    run_op("and", 3'b010, 8'hF0, 8'h3C, 3'b000);
    run_op("or", 3'b011, 8'h00, 8'h00, 3'b000);

    // Store to 0x30, then an asynchronous reset between edges must wipe it.
    run_op("sw_30", 3'b110, 8'h30, 8'h5A, 3'b000);
    run_op("lw_30", 3'b101, 8'h30, 8'h00, 3'b000);
    async_reset_pulse();
    run_op("lw_30_clr", 3'b101, 8'h30, 8'h00, 3'b000);
    check("lw_30_zero", {8'd0, writeback}, 16'h0000);

    // Store at the first edge after release executes.
    run_op("sw_rel", 3'b110, 8'h44, 8'h77, 3'b000);
    run_op("lw_rel", 3'b101, 8'h44, 8'h00, 3'b000);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] a;
      a = (n % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      if (n % 97 == 50) async_reset_pulse();
      run_op("rand", 3'($urandom_range(0, 7)), a, 8'($urandom_range(0, 255)),
             3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
